// File: rtl/fdd_track_emu.sv
// Virtual floppy drive: serialises a buffered raw MFM track as flux pulses and tracks head position/side.
// Defining FDD_TRACK_EMU_WRITE_EN adds capture of the write stream back into the track buffer.
module fdd_track_emu #(
    parameter int CELL_CLKS   = 56,
    parameter int RD_PULSE    = 8,
    parameter int TRACK_LEN   = 6250,
    parameter int INDEX_BYTES = 64,
    parameter int MAX_TRACK   = 83
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iMOTOR,
    input  logic        iSTEP,
    input  logic        iDIR,
    input  logic        iSIDE1,
    input  logic        iREADY,
    input  logic        iWP,
    output logic        oRDATA_n,
    output logic        oINDEX_n,
    output logic        oTR00_n,
    output logic        oWPRT_n,
    output logic [6:0]  oTRACK,
    output logic        oSIDE,
    output logic        oTRK_CHG,
    output logic [12:0] oBUF_ADDR,
    output logic        oBUF_REQ,
    input  logic        iBUF_ACK,
    input  logic [7:0]  iBUF_DATA,
    input  logic        iBUF_MARK,
`ifdef FDD_TRACK_EMU_WRITE_EN
    input  logic        iWG,
    input  logic        iWDATA,
    output logic        oBUF_WE,
    output logic [7:0]  oBUF_WDATA,
`endif
    output logic        oUNDERRUN
);
    localparam int CW = $clog2(CELL_CLKS);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SHIFT = 2'd2} state_t;

    state_t          stateR, stateNext;
    logic [12:0]     posR, posNext, posWrap;
    logic [15:0]     shiftR;
    logic [3:0]      cellCntR;
    logic [CW-1:0]   clkCntR;
    logic [7:0]      nextByteR, loadByte;
    logic [6:0]      trackR, trackNext;
    logic            prevBitR, reqR, nextValidR, nextMarkR;
    logic            rdataR, indexR, tr00R, wprtR, sideR, trkChgR, underrunR, stepPrevR;
    logic            runOk, stepEdge, trackMove, trkChgS, cellEnd, byteEnd, ackTaken, wgS;
    logic            loadFetch, loadShift, loadMark, underrunSet;

    // A1 sync marks drop the clock cell ahead of data bit 2 (0x44A9 -> 0x4489).
    function automatic logic [15:0] mfmEncode(input logic [7:0] dataByte, input logic prevBit,
                                              input logic isMark);
        logic [15:0] cells;
        logic        prev;
        cells = 16'h0000;
        prev  = prevBit;
        for (int i = 7; i >= 0; i--) begin
            cells[2*i+1] = ~prev & ~dataByte[i];
            cells[2*i]   = dataByte[i];
            prev         = dataByte[i];
        end
        if (isMark) begin
            cells[5] = 1'b0;
        end else begin
            cells[5] = cells[5];
        end
        return cells;
    endfunction

    // Step edge, clamped track update, cell/byte timing strobes.
    always_comb begin
        runOk    = iMOTOR & iREADY;
        stepEdge = iSTEP & ~stepPrevR;
        cellEnd  = (clkCntR == CW'(CELL_CLKS - 1));
        byteEnd  = cellEnd & (cellCntR == 4'd15);
        ackTaken = reqR & iBUF_ACK;
        posWrap  = (posR == 13'(TRACK_LEN - 1)) ? 13'd0 : posR + 13'd1;
        if (iDIR) begin
            trackNext = trackR + 7'd1;
            trackMove = stepEdge & (trackR != 7'(MAX_TRACK));
        end else begin
            trackNext = trackR - 7'd1;
            trackMove = stepEdge & (trackR != 7'd0);
        end
        trkChgS = trackMove | (iSIDE1 != sideR);
    end

    // Next-state logic and selection of the byte loaded into the cell shifter.
    always_comb begin
        stateNext   = stateR;
        loadFetch   = 1'b0;
        loadShift   = 1'b0;
        loadByte    = 8'h4E;
        loadMark    = 1'b0;
        underrunSet = 1'b0;
        if (!runOk) begin
            stateNext = IDLE;
        end else if (trkChgS) begin
            stateNext = FETCH;
        end else begin
            case (stateR)
                IDLE: stateNext = FETCH;
                FETCH: begin
                    if (ackTaken) begin
                        stateNext = SHIFT;
                        loadFetch = 1'b1;
                        loadByte  = iBUF_DATA;
                        loadMark  = iBUF_MARK;
                    end else begin
                        stateNext = FETCH;
                    end
                end
                SHIFT: begin
                    stateNext = SHIFT;
                    if (byteEnd) begin
                        loadShift = 1'b1;
                        if (nextValidR) begin
                            loadByte = nextByteR;
                            loadMark = nextMarkR;
                        end else if (ackTaken) begin
                            loadByte = iBUF_DATA;
                            loadMark = iBUF_MARK;
                        end else begin
                            underrunSet = 1'b1;
                        end
                    end else begin
                        loadShift = 1'b0;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
        posNext = loadShift ? posWrap : posR;
    end

    // FSM state register.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNext;
        end
    end

    // Head position, status pins and the read serialiser datapath.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            stepPrevR  <= 1'b0;
            sideR      <= 1'b0;
            trkChgR    <= 1'b0;
            wprtR      <= 1'b1;
            trackR     <= 7'd0;
            tr00R      <= 1'b0;
            posR       <= 13'd0;
            indexR     <= 1'b1;
            underrunR  <= 1'b0;
            rdataR     <= 1'b1;
            reqR       <= 1'b0;
            nextValidR <= 1'b0;
            nextByteR  <= 8'h00;
            nextMarkR  <= 1'b0;
            prevBitR   <= 1'b0;
            shiftR     <= 16'h0000;
            cellCntR   <= 4'd0;
            clkCntR    <= '0;
        end else begin
            stepPrevR <= iSTEP;
            sideR     <= iSIDE1;
            trkChgR   <= trkChgS;
            wprtR     <= ~iWP;
            if (trackMove) begin
                trackR <= trackNext;
                tr00R  <= (trackNext != 7'd0);
            end else begin
                trackR <= trackR;
            end
            posR   <= posNext;
            indexR <= ~((stateNext != IDLE) && (posNext < 13'(INDEX_BYTES)));
            if (underrunSet) begin
                underrunR <= 1'b1;
            end else begin
                underrunR <= underrunR;
            end
            case (stateNext)
                SHIFT: begin
                    if (loadFetch || loadShift) begin
                        shiftR     <= mfmEncode(loadByte, prevBitR, loadMark);
                        prevBitR   <= loadByte[0];
                        clkCntR    <= '0;
                        cellCntR   <= 4'd0;
                        nextValidR <= 1'b0;
                        reqR       <= 1'b0;
                        rdataR     <= 1'b1;
                    end else begin
                        if (ackTaken) begin
                            nextByteR  <= iBUF_DATA;
                            nextMarkR  <= iBUF_MARK;
                            nextValidR <= 1'b1;
                            reqR       <= 1'b0;
                        end else if (cellCntR == 4'd0 && clkCntR == '0 && !nextValidR) begin
                            reqR <= 1'b1;
                        end else begin
                            reqR <= reqR;
                        end
                        if (cellEnd) begin
                            clkCntR  <= '0;
                            cellCntR <= cellCntR + 4'd1;
                            shiftR   <= {shiftR[14:0], 1'b0};
                        end else begin
                            clkCntR <= clkCntR + CW'(1);
                        end
                        rdataR <= ~(shiftR[15] && (clkCntR < CW'(RD_PULSE)) && !wgS);
                    end
                end
                FETCH: begin
                    reqR       <= (stateR == FETCH);
                    nextValidR <= 1'b0;
                    rdataR     <= 1'b1;
                    clkCntR    <= '0;
                    cellCntR   <= 4'd0;
                end
                default: begin
                    reqR       <= 1'b0;
                    nextValidR <= 1'b0;
                    prevBitR   <= 1'b0;
                    rdataR     <= 1'b1;
                    clkCntR    <= '0;
                    cellCntR   <= 4'd0;
                end
            endcase
        end
    end

`ifdef FDD_TRACK_EMU_WRITE_EN
    logic       wrHitR, wrActR, weR, wrOnS, wrBitS;
    logic [7:0] wrByteR, wdataR;

    assign wgS    = iWG;
    assign wrOnS  = iWG & ~iWP;
    assign wrBitS = wrHitR | (wrOnS & iWDATA);

    // Collect data cells; the write strobe fires one cycle before the byte boundary so oBUF_ADDR still matches.
    always_ff @(posedge iCLK) begin
        if (iRESET || stateR != SHIFT) begin
            wrHitR  <= 1'b0;
            wrActR  <= 1'b0;
            wrByteR <= 8'h00;
            weR     <= 1'b0;
            wdataR  <= iRESET ? 8'h00 : wdataR;
        end else begin
            if (clkCntR == CW'(CELL_CLKS - 2) && cellCntR == 4'd15 && (wrActR || wrOnS)) begin
                weR    <= 1'b1;
                wdataR <= {wrByteR[6:0], wrBitS};
            end else begin
                weR <= 1'b0;
            end
            if (cellEnd) begin
                wrHitR <= 1'b0;
                if (cellCntR[0]) begin
                    wrByteR <= {wrByteR[6:0], wrBitS};
                end else begin
                    wrByteR <= wrByteR;
                end
                wrActR <= (cellCntR == 4'd15) ? 1'b0 : (wrActR | wrOnS);
            end else begin
                wrHitR <= wrBitS;
                wrActR <= wrActR | wrOnS;
            end
        end
    end

    assign oBUF_WE    = weR;
    assign oBUF_WDATA = wdataR;
`else
    assign wgS = 1'b0;
`endif

    assign oRDATA_n  = rdataR;
    assign oINDEX_n  = indexR;
    assign oTR00_n   = tr00R;
    assign oWPRT_n   = wprtR;
    assign oTRACK    = trackR;
    assign oSIDE     = sideR;
    assign oTRK_CHG  = trkChgR;
    assign oBUF_ADDR = posR;
    assign oBUF_REQ  = reqR;
    assign oUNDERRUN = underrunR;
endmodule
